simon_game_ctrl: RTL and testbench

- Top-level Simon Says sequencer that owns the colour sequence and round counter.
- Drives the colour-display block through its rst_display, en_display, seq_in_display, round_ctr and complete_display interface.
- Collects and checks the player's button presses, advances rounds, and declares win or lose.
- Sits between the seed source / button debouncers and the display block.

---
 rtl/simon_game_ctrl.sv | 140 ++++++++++++++
 tb/tb_simon_game_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/simon_game_ctrl.sv
// Simon Says sequencer: latches the colour sequence, drives the display block, checks presses, declares win/lose.
// Registered outputs track the state entered on each edge; no backpressure, presses outside WAIT_IN are dropped.
module simon_game_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES     = 2_500_000,
    parameter int unsigned MAX_ROUND      = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] seed,
    input  logic        btn_valid,
    input  logic [1:0]  btn_colour,
    input  logic        complete_display,
    output logic        rst_display,
    output logic        en_display,
    output logic [31:0] seq_out,
    output logic [3:0]  round_ctr,
    output logic        busy,
    output logic        win,
    output logic        lose
);
    localparam int unsigned TMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TW = $clog2(TMAX);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [3:0]    MAX_R        = 4'(MAX_ROUND);

    typedef enum logic [2:0] {
        S_IDLE, S_SHOW, S_CLR, S_WAIT_IN, S_GAP, S_WIN, S_LOSE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     seq_q, seq_d;
    logic [3:0]      round_q, round_d;
    logic [3:0]      in_pos_q, in_pos_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            rst_display_q, rst_display_d;
    logic            en_display_q, en_display_d;
    logic            busy_q, busy_d;
    logic            win_q, win_d;
    logic            lose_q, lose_d;
    logic [1:0]      exp_colour;

    assign exp_colour = seq_q[{in_pos_q, 1'b0} +: 2];

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        round_d  = round_q;
        in_pos_d = in_pos_q;
        timer_d  = timer_q;
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    seq_d   = seed;
                    round_d = 4'd0;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (complete_display) state_d = S_CLR;
            end
            S_CLR: begin
                in_pos_d = 4'd0;
                timer_d  = '0;
                state_d  = S_WAIT_IN;
            end
            S_WAIT_IN: begin
                // A press on the timeout cycle wins over the timeout.
                if (btn_valid) begin
                    timer_d = '0;
                    if (btn_colour != exp_colour) begin
                        state_d = S_LOSE;
                    end else if (in_pos_q != round_q) begin
                        in_pos_d = in_pos_q + 4'd1;
                    end else if (round_q == MAX_R) begin
                        state_d = S_WIN;
                    end else begin
                        round_d = round_q + 4'd1;
                        state_d = S_GAP;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = S_LOSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    state_d = S_SHOW;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rst_display_d = (state_d != S_SHOW);
        en_display_d  = (state_d == S_SHOW);
        busy_d        = (state_d == S_SHOW) || (state_d == S_WAIT_IN) || (state_d == S_GAP);
        win_d         = (state_d == S_WIN);
        lose_d        = (state_d == S_LOSE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            seq_q         <= '0;
            round_q       <= '0;
            in_pos_q      <= '0;
            timer_q       <= '0;
            rst_display_q <= 1'b1;
            en_display_q  <= 1'b0;
            busy_q        <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            seq_q         <= seq_d;
            round_q       <= round_d;
            in_pos_q      <= in_pos_d;
            timer_q       <= timer_d;
            rst_display_q <= rst_display_d;
            en_display_q  <= en_display_d;
            busy_q        <= busy_d;
            win_q         <= win_d;
            lose_q        <= lose_d;
        end
    end

    assign rst_display = rst_display_q;
    assign en_display  = en_display_q;
    assign seq_out     = seq_q;
    assign round_ctr   = round_q;
    assign busy        = busy_q;
    assign win         = win_q;
    assign lose        = lose_q;
endmodule

// File: tb/tb_simon_game_ctrl.sv
// Bench for simon_game_ctrl: game-level player model with a behavioural display block and randomized games.
module tb_simon_game_ctrl;
    localparam int TO = 20, GAP = 3, MAXR = 2, DISP_DELAY = 5;
    localparam int M_WIN = 0, M_WRONG = 1, M_TIMEOUT = 2, M_EDGE = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic [31:0] seed = '0;
    logic        btn_valid = 1'b0;
    logic [1:0]  btn_colour = '0;
    logic        complete_display;
    logic        rst_display, en_display, busy, win, lose;
    logic [31:0] seq_out;
    logic [3:0]  round_ctr;
    int          disp_cnt;
    int          checks = 0;
    int          failures = 0;

    simon_game_ctrl #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP), .MAX_ROUND(MAXR)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .btn_valid(btn_valid), .btn_colour(btn_colour), .complete_display(complete_display),
        .rst_display(rst_display), .en_display(en_display), .seq_out(seq_out),
        .round_ctr(round_ctr), .busy(busy), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;

    // Display block: raises a sticky done flag DISP_DELAY enabled cycles after release from reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || rst_display) begin
            disp_cnt         <= 0;
            complete_display <= 1'b0;
        end else if (en_display) begin
            disp_cnt <= disp_cnt + 1;
            if (disp_cnt == DISP_DELAY - 1) complete_display <= 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_rst, input logic e_en, input logic e_busy,
                            input logic e_win, input logic e_lose, input int e_round, input logic [31:0] e_seq);
        chk({tag, "_rst_display"}, rst_display, e_rst);
        chk({tag, "_en_display"}, en_display, e_en);
        chk({tag, "_busy"}, busy, e_busy);
        chk({tag, "_win"}, win, e_win);
        chk({tag, "_lose"}, lose, e_lose);
        chk({tag, "_round_ctr"}, round_ctr, e_round);
        chk({tag, "_seq_out"}, seq_out, e_seq);
    endtask

    function automatic logic [1:0] col_of(input logic [31:0] s, input int i);
        logic [31:0] t;
        t = s >> (2 * i);
        return t[1:0];
    endfunction

    task automatic start_game(input logic [31:0] s);
        seed  = s;
        start = 1'b1;
        tick;
        start = 1'b0;
        seed  = ~s;
        chk_outs("start", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, s);
    endtask

    // Runs from the first SHOW cycle through CLR to the first WAIT_IN cycle.
    task automatic show_phase(input int r, input logic [31:0] s, input bit noise);
        int n;
        n = 0;
        while (en_display === 1'b1 && n < 40) begin
            n++;
            start      = noise && n == 2;
            btn_valid  = noise && n == 3;
            btn_colour = 2'($urandom);
            seed       = $urandom;
            tick;
            start     = 1'b0;
            btn_valid = 1'b0;
        end
        chk("show_len", n, DISP_DELAY + 1);
        chk("clr_en_display", en_display, 1'b0);
        chk("clr_rst_display", rst_display, 1'b1);
        chk("clr_round_ctr", round_ctr, r);
        chk("clr_seq_out", seq_out, s);
        tick;
        chk_outs("wait_in", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r, s);
    endtask

    task automatic gap_phase(input int r, input logic [31:0] s, input bit noise);
        for (int i = 0; i < GAP; i++) begin
            chk_outs("gap", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r, s);
            start      = noise && i == 0;
            btn_valid  = noise && i == 1;
            btn_colour = 2'($urandom);
            seed       = $urandom;
            tick;
            start     = 1'b0;
            btn_valid = 1'b0;
        end
        chk_outs("gap_to_show", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, r, s);
    endtask

    task automatic after_end(input string tag, input logic e_win, input logic e_lose,
                             input int r, input logic [31:0] s);
        for (int i = 0; i < 4; i++) begin
            btn_valid  = 1'b1;
            btn_colour = 2'(i);
            tick;
            btn_valid = 1'b0;
            tick;
        end
        chk_outs(tag, 1'b1, 1'b0, 1'b0, e_win, e_lose, r, s);
    endtask

    task automatic run_game(input logic [31:0] s, input int mode, input int fr, input int fp,
                            input logic [1:0] wmask, input bit noise);
        logic [1:0] col;
        int         k;
        bit         here;
        start_game(s);
        for (int r = 0; r <= MAXR; r++) begin
            show_phase(r, s, noise);
            for (int p = 0; p <= r; p++) begin
                here = (r == fr) && (p == fp);
                if (mode == M_TIMEOUT && here) begin
                    repeat (TO - 1) tick;
                    chk("pre_timeout_lose", lose, 1'b0);
                    tick;
                    chk_outs("timeout", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, r, s);
                    after_end("timeout_hold", 1'b0, 1'b1, r, s);
                    return;
                end
                k = (mode == M_EDGE) ? TO - 1 : int'($urandom_range(0, 4));
                repeat (k) tick;
                col = col_of(s, p);
                if (mode == M_WRONG && here) col = col ^ wmask;
                btn_colour = col;
                btn_valid  = 1'b1;
                tick;
                btn_valid = 1'b0;
                if (mode == M_WRONG && here) begin
                    chk_outs("wrong", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, r, s);
                    after_end("lose_hold", 1'b0, 1'b1, r, s);
                    return;
                end
                if (p < r) chk_outs("mid_round", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r, s);
            end
            if (r == MAXR) begin
                chk_outs("win", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, r, s);
                after_end("win_hold", 1'b1, 1'b0, r, s);
                return;
            end
            chk_outs("round_up", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r + 1, s);
            gap_phase(r + 1, s, noise);
        end
    endtask

    initial begin
        int mode, fr, fp;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick;
        chk_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        rst_n = 1'b1;
        tick;
        chk_outs("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);

        run_game(32'h0000_0039, M_WIN, 0, 0, 2'b01, 1'b0);
        run_game(32'h0000_0039, M_WRONG, 1, 1, 2'b01, 1'b0);
        run_game($urandom, M_TIMEOUT, 0, 0, 2'b01, 1'b0);
        run_game($urandom, M_EDGE, 0, 0, 2'b01, 1'b0);
        run_game($urandom, M_WIN, 0, 0, 2'b01, 1'b1);

        start_game(32'h1234_5678);
        show_phase(0, 32'h1234_5678, 1'b0);
        repeat (3) tick;
        #2 rst_n = 1'b0;
        #1 chk_outs("async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        tick;
        rst_n = 1'b1;
        tick;
        chk_outs("post_rst_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        run_game(32'hFFFF_FFFF, M_WIN, 0, 0, 2'b01, 1'b0);

        for (int g = 0; g < 8; g++) begin
            mode = int'($urandom_range(0, 3));
            fr   = int'($urandom_range(0, MAXR));
            fp   = int'($urandom_range(0, fr));
            run_game($urandom, mode, fr, fp, 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
